// File: rtl/bip2_pkg.sv
// Shared BIP-2 definitions: opcode encodings and the sequencer state encoding.
package bip2_pkg;

    localparam logic [4:0] OP_HLT = 5'b00000;
    localparam logic [4:0] OP_BEQ = 5'b01000;
    localparam logic [4:0] OP_BNE = 5'b01001;
    localparam logic [4:0] OP_BGT = 5'b01010;
    localparam logic [4:0] OP_BGE = 5'b01011;
    localparam logic [4:0] OP_BLT = 5'b01100;
    localparam logic [4:0] OP_BLE = 5'b01101;
    localparam logic [4:0] OP_JMP = 5'b01110;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode: opcode plus Z/N status flags -> branch taken.
module branch_cond #(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0] opcode_i,
    input  logic            z_i,
    input  logic            n_i,
    output logic            take_o
);
    import bip2_pkg::*;

    always_comb begin
        take_o = 1'b0;
        case (opcode_i)
            OP_W'(OP_BEQ): take_o = z_i;
            OP_W'(OP_BNE): take_o = !z_i;
            OP_W'(OP_BGT): take_o = !z_i && !n_i;
            OP_W'(OP_BGE): take_o = !n_i;
            OP_W'(OP_BLT): take_o = n_i;
            OP_W'(OP_BLE): take_o = n_i || z_i;
            OP_W'(OP_JMP): take_o = 1'b1;
            default:       take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_2x1.sv
// Generic two-input mux: y = sel ? b : a.
module mux_2x1 #(
    parameter int W = 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sel_i,
    output logic [W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/pc_sequencer.sv
// BIP-2 program-counter sequencer: FETCH/EXEC/HALT control, PC register and branch select.
// Define PC_STALL_EN to add the stall_i freeze port.
module pc_sequencer #(
    parameter int MSB_ROM = 11,
    parameter int LSB     = 0,
    parameter int OP_W    = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [OP_W-1:0]      opcode_i,
    input  logic [MSB_ROM-1:LSB] operand_i,
    input  logic                 z_flag_i,
    input  logic                 n_flag_i,
`ifdef PC_STALL_EN
    input  logic                 stall_i,
`endif
    output logic [MSB_ROM-1:LSB] pc_o,
    output logic                 branch_o,
    output logic                 fetch_o,
    output logic                 exec_o,
    output logic                 halted_o
);
    import bip2_pkg::*;

    localparam int AW = MSB_ROM - LSB;
    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_e               state_q, state_d;
    logic [MSB_ROM-1:LSB] pc_q, pc_d, pc_inc, pc_next;
    logic                 stall;
    logic                 take;

`ifdef PC_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    branch_cond #(.OP_W(OP_W)) u_cond (
        .opcode_i (opcode_i),
        .z_i      (z_flag_i),
        .n_i      (n_flag_i),
        .take_o   (take)
    );

    // Wraps modulo 2^AW with no carry out.
    assign pc_inc   = pc_q + PC_ONE;
    assign branch_o = exec_o && take;

    mux_2x1 #(.W(AW)) u_next_pc (
        .a_i   (pc_inc),
        .b_i   (operand_i),
        .sel_i (branch_o),
        .y_o   (pc_next)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fetch_o  = 1'b0;
        exec_o   = 1'b0;
        halted_o = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (!stall) begin
                    fetch_o = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // A stalled EXEC re-runs with fresh flags once released.
                if (!stall) begin
                    exec_o = 1'b1;
                    if (opcode_i == OP_W'(OP_HLT)) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_next;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: halted_o = 1'b1;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: per-cycle model comparison plus hand-computed directed vectors.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  opcode = 5'b00001;
    logic [10:0] operand = '0;
    logic        z = 1'b0;
    logic        n = 1'b0;
    logic        stall = 1'b0;
    logic [10:0] pc_o;
    logic        branch_o, fetch_o, exec_o, halted_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .opcode_i  (opcode),
        .operand_i (operand),
        .z_flag_i  (z),
        .n_flag_i  (n),
`ifdef PC_STALL_EN
        .stall_i   (stall),
`endif
        .pc_o      (pc_o),
        .branch_o  (branch_o),
        .fetch_o   (fetch_o),
        .exec_o    (exec_o),
        .halted_o  (halted_o)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 = fetch cycle, 1 = execute cycle, 2 = halted.
    int m_pc = 0;
    int m_phase = 0;

    function automatic bit rule_take(input logic [4:0] op, input bit zf, input bit nf);
        case (op)
            5'b01000: return zf;
            5'b01001: return !zf;
            5'b01010: return !zf && !nf;
            5'b01011: return !nf;
            5'b01100: return nf;
            5'b01101: return nf || zf;
            5'b01110: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0;
            m_phase = 0;
        end else if (m_phase != 2 && !stall) begin
            if (m_phase == 0) m_phase = 1;
            else if (opcode == 5'b00000) m_phase = 2;
            else begin
                m_pc = rule_take(opcode, z, n) ? int'(operand) : (m_pc + 1) % 2048;
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit e_fetch, e_exec;
        e_fetch = (m_phase == 0) && !stall;
        e_exec  = (m_phase == 1) && !stall;
        chk("model pc_o", int'(pc_o), m_pc);
        chk("model fetch_o", int'(fetch_o), int'(e_fetch));
        chk("model exec_o", int'(exec_o), int'(e_exec));
        chk("model halted_o", int'(halted_o), int'(m_phase == 2));
        chk("model branch_o", int'(branch_o), int'(e_exec && rule_take(opcode, z, n)));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called early in a FETCH cycle; leaves the bench early in the following cycle.
    task automatic instr(input logic [4:0] op, input logic [10:0] opd, input bit zf,
                         input bit nf, input bit exp_br);
        opcode = op; operand = opd; z = zf; n = nf;
        cyc();
        chk("exec_o in EXEC", int'(exec_o), 1);
        chk("fetch_o in EXEC", int'(fetch_o), 0);
        chk("branch_o in EXEC", int'(branch_o), int'(exp_br));
        cyc();
    endtask

    initial begin
        repeat (3) cyc();
        chk("reset pc_o", int'(pc_o), 0);
        chk("reset exec_o", int'(exec_o), 0);
        chk("reset halted_o", int'(halted_o), 0);
        chk("reset branch_o", int'(branch_o), 0);
        rst_n = 1'b1;
        #1;
        chk("fetch_o after release", int'(fetch_o), 1);

        for (int i = 1; i <= 3; i++) begin
            instr(5'b00001, 11'h555, 1'b1, 1'b0, 1'b0);
            chk("ADD stream pc", int'(pc_o), i);
        end

        instr(5'b01000, 11'h123, 1'b1, 1'b0, 1'b1);
        chk("BEQ taken pc", int'(pc_o), 'h123);
        instr(5'b01000, 11'h123, 1'b0, 1'b0, 1'b0);
        chk("BEQ not taken pc", int'(pc_o), 'h124);
        instr(5'b01101, 11'h200, 1'b0, 1'b0, 1'b0);
        chk("BLE not taken pc", int'(pc_o), 'h125);
        instr(5'b01100, 11'h300, 1'b0, 1'b1, 1'b1);
        chk("BLT taken pc", int'(pc_o), 'h300);
        instr(5'b01001, 11'h400, 1'b0, 1'b0, 1'b1);
        chk("BNE taken pc", int'(pc_o), 'h400);
        instr(5'b01010, 11'h500, 1'b0, 1'b0, 1'b1);
        chk("BGT taken pc", int'(pc_o), 'h500);
        instr(5'b01011, 11'h600, 1'b0, 1'b1, 1'b0);
        chk("BGE not taken pc", int'(pc_o), 'h501);
        instr(5'b01110, 11'h010, 1'b0, 1'b0, 1'b1);
        chk("JMP pc", int'(pc_o), 'h010);
        instr(5'b10101, 11'h7FF, 1'b1, 1'b1, 1'b0);
        chk("undefined opcode pc", int'(pc_o), 'h011);
        instr(5'b01110, 11'h7FF, 1'b0, 1'b0, 1'b1);
        instr(5'b11111, 11'h000, 1'b0, 1'b0, 1'b0);
        chk("wrap pc", int'(pc_o), 'h000);

`ifdef PC_STALL_EN
        instr(5'b01110, 11'h100, 1'b0, 1'b0, 1'b1);
        opcode = 5'b01001; operand = 11'h222; z = 1'b0; n = 1'b0;
        cyc();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall pc frozen", int'(pc_o), 'h100);
            chk("stall exec_o", int'(exec_o), 0);
            cyc();
        end
        stall = 1'b0;
        #1;
        chk("post-stall exec_o", int'(exec_o), 1);
        chk("post-stall branch_o", int'(branch_o), 1);
        cyc();
        chk("post-stall BNE pc", int'(pc_o), 'h222);
        stall = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset during stall pc", int'(pc_o), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        stall = 1'b0;
`endif

        instr(5'b01110, 11'h050, 1'b0, 1'b0, 1'b1);
        instr(5'b00000, 11'h3AA, 1'b1, 1'b0, 1'b0);
        chk("HLT halted_o", int'(halted_o), 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) stall = 1'b1;
            if (i == 10) stall = 1'b0;
            opcode = 5'b01110;
            cyc();
            chk("HALT pc hold", int'(pc_o), 'h050);
            chk("HALT fetch_o", int'(fetch_o), 0);
            chk("HALT halted_o", int'(halted_o), 1);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
